// File: rtl/wam_pkg.sv
// Shared definitions for the whack-a-mole flick scheduler: state encoding,
// parameter defaults and the LFSR feedback taps.
package wam_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    ON   = 2'd2,
    DONE = 2'd3
  } flick_state_t;

  localparam int          DEF_NUM_LIGHTS = 9;
  localparam int          DEF_TIME_W     = 28;
  localparam logic [15:0] DEF_SEED       = 16'hACE1;

  // x^16 + x^14 + x^13 + x^11 + 1 -> feedback from bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/flick_lfsr.sv
// Free-running 16-bit Fibonacci LFSR with its low nibble folded into 0..NUM_LIGHTS-1.
module flick_lfsr
  import wam_pkg::*;
#(
  parameter int          NUM_LIGHTS = DEF_NUM_LIGHTS,
  parameter logic [15:0] SEED       = DEF_SEED
) (
  input  logic       clk,
  input  logic       reset,
  output logic [3:0] pos
);

  logic [15:0] lfsr;

  // Runs in every state so the light sequence depends on when the player presses start.
  always_ff @(posedge clk) begin
    if (reset) lfsr <= SEED;
    else       lfsr <= {lfsr[14:0], ^(lfsr & LFSR_TAPS)};
  end

  always_comb begin
    pos = lfsr[3:0];
    if (lfsr[3:0] >= 4'(NUM_LIGHTS)) pos = lfsr[3:0] - 4'(NUM_LIGHTS);
  end

endmodule

// File: rtl/flick_scheduler.sv
// Whack-a-mole round sequencer: gap/lit alternation, hit judging and counters.
// Optional macro FLICK_WRONG_KEY_PENALTY_EN makes a wrong key in ON an immediate miss.
module flick_scheduler
  import wam_pkg::*;
#(
  parameter int          NUM_LIGHTS = DEF_NUM_LIGHTS,
  parameter int          TIME_W     = DEF_TIME_W,
  parameter logic [15:0] SEED       = DEF_SEED
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [TIME_W-1:0]     time_between,
  input  logic [TIME_W-1:0]     time_on,
  input  logic [5:0]            max_flicks,
  input  logic                  use_lives,
  input  logic [3:0]            lives_init,
  input  logic                  key_valid,
  input  logic [3:0]            key,
  output logic [NUM_LIGHTS-1:0] lights,
  output logic [3:0]            light_pos,
  output logic                  light_change,
  output logic [5:0]            flick_count,
  output logic [5:0]            hits,
  output logic [3:0]            lives_left,
  output logic                  busy,
  output logic                  done
);

  flick_state_t      state;
  logic [TIME_W-1:0] timer;
  logic [3:0]        pos;
  logic              hit, wrong, lit_end, end_round;
  logic [3:0]        lives_nx;
  logic [5:0]        flick_nx;

  flick_lfsr #(.NUM_LIGHTS(NUM_LIGHTS), .SEED(SEED)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .pos   (pos)
  );

  always_comb begin
    hit = key_valid && (key == light_pos);
`ifdef FLICK_WRONG_KEY_PENALTY_EN
    wrong = key_valid && (key != light_pos);
`else
    wrong = 1'b0;
`endif
    lit_end  = hit || wrong || (timer == time_on);
    // A hit always wins, even on the final lit cycle.
    lives_nx = (!hit && use_lives && lives_left != 4'd0) ? lives_left - 4'd1 : lives_left;
    flick_nx = flick_count + 6'd1;
    end_round = (max_flicks != 6'd0 && flick_nx == max_flicks) ||
                (use_lives && lives_nx == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      timer        <= '0;
      lights       <= '0;
      light_pos    <= '0;
      light_change <= 1'b0;
      flick_count  <= '0;
      hits         <= '0;
      lives_left   <= '0;
    end else begin
      light_change <= 1'b0;
      if (abort) begin
        state  <= IDLE;
        lights <= '0;
        timer  <= '0;
      end else if (start) begin
        state       <= GAP;
        lights      <= '0;
        timer       <= '0;
        flick_count <= '0;
        hits        <= '0;
        lives_left  <= lives_init;
      end else begin
        unique case (state)
          GAP: begin
            if (timer == time_between) begin
              state     <= ON;
              timer     <= '0;
              light_pos <= pos;
              lights    <= {{(NUM_LIGHTS-1){1'b0}}, 1'b1} << pos;
            end else begin
              timer <= timer + TIME_W'(1);
            end
          end
          ON: begin
            if (lit_end) begin
              state        <= end_round ? DONE : GAP;
              timer        <= '0;
              lights       <= '0;
              light_change <= 1'b1;
              flick_count  <= flick_nx;
              lives_left   <= lives_nx;
              if (hit && hits != 6'd63) hits <= hits + 6'd1;
            end else begin
              timer <= timer + TIME_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign busy = (state == GAP) || (state == ON);
  assign done = (state == DONE);

endmodule

// File: tb/tb_flick_scheduler.sv
// Scoreboard bench for flick_scheduler: per-flick expectations queued at stimulus time.
module tb_flick_scheduler;
  import wam_pkg::*;

  localparam int NL = 9;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0;
  logic [27:0]   time_between = 28'd4, time_on = 28'd9;
  logic [5:0]    max_flicks = 6'd0;
  logic          use_lives = 1'b0, key_valid = 1'b0;
  logic [3:0]    lives_init = 4'd3, key = 4'd0;
  logic [NL-1:0] lights;
  logic [3:0]    light_pos, lives_left;
  logic          light_change, busy, done;
  logic [5:0]    flick_count, hits;

  int nchk = 0, nerr = 0;
  int m_flicks, m_hits, m_lives;

  typedef struct {int flicks; int hits; int lives; int done; int lit;} exp_t;
  exp_t sb[$];

  logic [15:0] m_lfsr;

  flick_scheduler dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .time_between(time_between), .time_on(time_on), .max_flicks(max_flicks),
    .use_lives(use_lives), .lives_init(lives_init), .key_valid(key_valid), .key(key),
    .lights(lights), .light_pos(light_pos), .light_change(light_change),
    .flick_count(flick_count), .hits(hits), .lives_left(lives_left),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic int fold(logic [3:0] v);
    return (int'(v) >= NL) ? int'(v) - NL : int'(v);
  endfunction

  task automatic chk(string tag, int got, int exp);
    nchk++;
    if (got != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Entered at the negedge of the first gap cycle; leaves at the first lit cycle.
  task automatic wait_on(output int ep);
    int gap = 0, prev = 0, extra = 0;
    while (lights == '0 && gap < 300) begin
      if (gap > 0 && light_change) extra++;
      prev = fold(m_lfsr[3:0]);
      gap++;
      @(negedge clk);
    end
    chk("gap_len", gap, int'(time_between) + 1);
    chk("lc_extra", extra, 0);
    ep = prev;
    chk("light_pos", int'(light_pos), ep);
    chk("lights_onehot", int'(lights), 1 << ep);
  endtask

  task automatic do_flick(input int hit_at, input int wrong);
    int ep, lit, is_hit, pen;
    exp_t e, g;
    lit = 0;
    pen = 0;
    wait_on(ep);
`ifdef FLICK_WRONG_KEY_PENALTY_EN
    pen = wrong;
`endif
    is_hit = (hit_at > 0 && wrong == 0) ? 1 : 0;
    e.lit = (hit_at > 0 && (is_hit != 0 || pen != 0)) ? hit_at : int'(time_on) + 1;
    m_flicks++;
    if (is_hit != 0 && m_hits < 63) m_hits++;
    if (is_hit == 0 && use_lives && m_lives > 0) m_lives--;
    e.flicks = m_flicks;
    e.hits   = m_hits;
    e.lives  = m_lives;
    e.done   = ((max_flicks != 0 && m_flicks == int'(max_flicks)) ||
                (use_lives && m_lives == 0)) ? 1 : 0;
    sb.push_back(e);
    while (lights != '0 && lit < 300) begin
      lit++;
      key_valid = (lit == hit_at);
      key = (wrong != 0) ? 4'((ep + 1) % NL) : 4'(ep);
      @(negedge clk);
    end
    key_valid = 1'b0;
    g = sb.pop_front();
    chk("lit_len", lit, g.lit);
    chk("light_change", int'(light_change), 1);
    chk("flick_count", int'(flick_count), g.flicks);
    chk("hits", int'(hits), g.hits);
    chk("lives_left", int'(lives_left), g.lives);
    chk("done", int'(done), g.done);
    chk("busy", int'(busy), 1 - g.done);
  endtask

  task automatic do_start(input int lives);
    m_flicks = 0;
    m_hits   = 0;
    m_lives  = lives;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_flicks", int'(flick_count), 0);
    chk("start_hits", int'(hits), 0);
    chk("start_lives", int'(lives_left), lives);
    chk("start_busy", int'(busy), 1);
  endtask

  initial begin
    int ep, lc;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_lights", int'(lights), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_flicks", int'(flick_count), 0);
    chk("rst_hits", int'(hits), 0);
    chk("rst_lives", int'(lives_left), 0);
    chk("rst_pos", int'(light_pos), 0);
    repeat (4) @(negedge clk);

    // Round 1: timeout, hit on 3rd lit cycle, wrong key
    do_start(3);
    do_flick(0, 0);
    do_flick(3, 0);
    do_flick(2, 1);

    // Abort in the middle of a lit period
    wait_on(ep);
    repeat (2) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_lights", int'(lights), 0);
    chk("abort_lc", int'(light_change), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_flicks", int'(flick_count), m_flicks);
    chk("abort_hits", int'(hits), m_hits);
    lc = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (light_change || lights != '0) lc++;
    end
    chk("idle_quiet", lc, 0);

    // Round 2: lives mode, two timeouts end the round
    use_lives  = 1'b1;
    lives_init = 4'd2;
    do_start(2);
    do_flick(0, 0);
    do_flick(0, 0);
    @(negedge clk);
    chk("lives_done_hold", int'(done), 1);
    chk("lives_done_lights", int'(lights), 0);

    // Round 3 from DONE: flick limit, last hit on the timeout cycle
    use_lives  = 1'b0;
    lives_init = 4'd5;
    max_flicks = 6'd3;
    do_start(5);
    do_flick(1, 0);
    do_flick(5, 0);
    do_flick(10, 0);
    repeat (3) @(negedge clk);
    chk("max_done_hold", int'(done), 1);
    chk("max_hits_hold", int'(hits), 3);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
